logic_slr_toggle_load: RTL and testbench
========================================

# logic_slr_toggle_load

Parameterised synthetic switching-activity load for board power measurement. It holds a chain of `NUM_LOGIC_BLOCK` registered `data_width`-bit fabric stages. A pattern source feeds the chain and toggles a run-time-programmable percentage of cycles (0-100 %). The top level instantiates several copies, all sharing one clock, one reset and one `TOGGLE_RATE` control, and XORs their 1-bit outputs into a debug observation signal.

## Interface
Parameters:
- `NUM_LOGIC_BLOCK`, default 2500: number of pipeline stages; legal values ≥ 1.
- `data_width`, default 32: bits per stage; legal values ≥ 2.

Ports:
- `clk`, input, 1: the single clock; every register uses its rising edge.
- `rst`, input, 1: reset, asynchronous and active-low. 0 clears all state immediately.
- `TOGGLE_RATE`, input, 7: activity percentage. Values ≥ 100 mean 100 %. Sampled every cycle, no synchroniser.
- `logic_o`, output, 1: registered observation bit taken from the last stage.

## Operation
- Rate counter `cnt`, 7 bits:
  - Counts 0,1,…,99 and wraps from 99 to 0.
  - Advances every cycle, regardless of `TOGGLE_RATE`.
- Enable: `en = (cnt < TOGGLE_RATE)`, combinational, unsigned compare.
  - `TOGGLE_RATE = 0`: `en` is never set.
  - `TOGGLE_RATE` ≥ 100: `en` is always set.
  - `TOGGLE_RATE = R` (1-99): `en` is set for exactly R cycles per 100-cycle window (cnt 0..R-1).
- Source register `src` [data_width-1:0]: `src <= ~src` when `en` is set, otherwise it holds. Every bit toggles on each enabled cycle.
- Stage chain `stage[0..NUM_LOGIC_BLOCK-1]`, each `data_width` bits:
  - `stage[0] <= src`.
  - `stage[i] <= {stage[i-1][data_width-2:0], stage[i-1][data_width-1]}` (rotate left 1), for i ≥ 1.
  - The chain shifts every cycle, unconditionally.
- Output: `logic_o <= stage[NUM_LOGIC_BLOCK-1][0]`.
- Every `stage`, `src` and `logic_o` register carries a keep/dont_touch attribute so that synthesis preserves the full chain. The chain is the power load, so it must not be collapsed even though it is logically redundant.
- Reset (`rst` = 0):
  - `cnt`, `src`, every `stage` and `logic_o` clear to 0 asynchronously.
  - Assertion mid-operation aborts the pattern immediately.
  - After release, behaviour is identical to a fresh power-up.
- Changing `TOGGLE_RATE` mid-window: the new value applies from the next compare, and `cnt` is not restarted.

## Timing
- All outputs are 0 during reset and for at least the first `NUM_LOGIC_BLOCK+1` edges after release.
- Latency from `src` to `logic_o` is `NUM_LOGIC_BLOCK+1` cycles: after edge e, `logic_o` equals `src[0]` as it was after edge e-`NUM_LOGIC_BLOCK`-1.
- Edge 1 is the first rising edge after reset release. With `en` always set, `src` is all-ones after odd edges and all-zeros after even edges.
- With `TOGGLE_RATE` ≥ 100, `logic_o` first rises after edge `NUM_LOGIC_BLOCK+2`, then toggles every cycle.
- Steady state: `logic_o` toggles exactly `min(TOGGLE_RATE,100)` times per 100 consecutive cycles.
- There is no handshake. Throughput is one stage shift per clock.
- Every stage is a single register-to-register hop, so the chain must meet timing at the system clock.

## Test plan
Use `NUM_LOGIC_BLOCK = 4` and `data_width = 8` unless noted.
1. Reset, release, `TOGGLE_RATE = 127` -> `logic_o` = 0 through edge 5, 1 after edge 6, then alternates 0/1 every cycle.
2. `TOGGLE_RATE = 0` for 1000 cycles -> `logic_o`, `src` and all stages stay 0.
3. `TOGGLE_RATE = 50`, run 1000 cycles past the pipeline fill -> 500 `logic_o` transitions. `TOGGLE_RATE = 1` -> 10 transitions. `TOGGLE_RATE = 100` -> 1000 transitions.
4. Check `cnt` wrap: with `TOGGLE_RATE = 25`, `en` is high for cnt 0..24 and low for 25..99. `cnt` goes 99 -> 0.
5. Assert `rst` low asynchronously (between edges) mid-run with `TOGGLE_RATE = 127` -> `logic_o` = 0 at once with no clock edge. After release, sequence 1 repeats exactly.
6. `NUM_LOGIC_BLOCK = 1`, `data_width = 2`, `TOGGLE_RATE = 127` -> `logic_o` first 1 after edge 3.

Source files
------------

// File: rtl/logic_slr_toggle_load.sv
// Synthetic switching-activity load for board power measurement.
// A rate counter gates an inverting pattern source that feeds a long chain
// of registered stages. A programmable fraction of cycles carries a full
// toggle through every stage. The chain is logically redundant. Keep
// attributes stop synthesis from collapsing it, because the chain is the
// power load.
module logic_slr_toggle_load #(
  parameter int NUM_LOGIC_BLOCK = 2500,
  parameter int data_width      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] TOGGLE_RATE,
  output logic       logic_o
);

  localparam logic [6:0] CNT_LAST = 7'd99;

  logic [6:0] cnt;
  logic       en;

  (* keep = "true", dont_touch = "true" *)
  logic [data_width-1:0] src;

  (* keep = "true", dont_touch = "true" *)
  logic [data_width-1:0] stage [NUM_LOGIC_BLOCK];

  (* keep = "true", dont_touch = "true" *)
  logic logic_o_q;

  // 100-cycle window counter, free-running regardless of the rate setting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 7'd1;
    end
  end

  // Rates of 100 or more always satisfy the compare, because cnt never exceeds 99
  assign en = (cnt < TOGGLE_RATE);

  // Pattern source: every bit flips on each enabled cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src <= '0;
    end else if (en) begin
      src <= ~src;
    end
  end

  // Stage chain: stage 0 loads the source, later stages rotate left by one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LOGIC_BLOCK; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= src;
      for (int i = 1; i < NUM_LOGIC_BLOCK; i++) begin
        stage[i] <= {stage[i-1][data_width-2:0], stage[i-1][data_width-1]};
      end
    end
  end

  // Registered observation bit from the tail of the chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      logic_o_q <= 1'b0;
    end else begin
      logic_o_q <= stage[NUM_LOGIC_BLOCK-1][0];
    end
  end

  assign logic_o = logic_o_q;

endmodule

// File: tb/tb_logic_slr_toggle_load.sv
// Bench for logic_slr_toggle_load: two instances (4x8 and 1x2) share the
// clock, the reset and the rate. The reference model keeps the history of
// the source bit. Each output is compared against that history, delayed by
// the chain latency.
module tb_logic_slr_toggle_load;

  logic       clk;
  logic       rst;
  logic [6:0] rate;
  logic       lo_a;
  logic       lo_b;

  int checks;
  int errors;
  int e;
  bit src_m;
  bit hist[$];
  int toggles;
  logic prev;

  logic_slr_toggle_load #(.NUM_LOGIC_BLOCK(4), .data_width(8)) dut_a (
    .clk(clk), .rst(rst), .TOGGLE_RATE(rate), .logic_o(lo_a)
  );

  logic_slr_toggle_load #(.NUM_LOGIC_BLOCK(1), .data_width(2)) dut_b (
    .clk(clk), .rst(rst), .TOGGLE_RATE(rate), .logic_o(lo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at edge %0d", tag, obs, exp, e);
    end
  endtask

  // Source bit as it was after edge k (edge 0 = reset state)
  function automatic bit hb(input int k);
    if (k < 0) return 1'b0;
    return hist[k];
  endfunction

  task automatic model_reset();
    e = 0;
    src_m = 1'b0;
    hist.delete();
    hist.push_back(1'b0);
  endtask

  // One clock edge: advance the model and compare every observable
  task automatic step();
    @(posedge clk);
    e++;
    if (((e - 1) % 100) < int'(rate)) src_m = ~src_m;
    hist.push_back(src_m);
    #1;
    chk("cnt_a", 32'(dut_a.cnt), e % 100);
    chk("cnt_b", 32'(dut_b.cnt), e % 100);
    chk("en_a", 32'(dut_a.en), 32'((e % 100) < int'(rate)));
    chk("src_a", 32'(dut_a.src), hist[e] ? 32'hFF : 32'h0);
    chk("src_b", 32'(dut_b.src), hist[e] ? 32'h3 : 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("stage_a", 32'(dut_a.stage[i]), hb(e - 1 - i) ? 32'hFF : 32'h0);
    end
    chk("logic_o_a", 32'(lo_a), 32'(hb(e - 5)));
    chk("logic_o_b", 32'(lo_b), 32'(hb(e - 2)));
  endtask

  // Asserts reset between edges, checks the immediate clear, then releases on a negedge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_lo_a", 32'(lo_a), 0);
    chk("rst_lo_b", 32'(lo_b), 0);
    chk("rst_cnt_a", 32'(dut_a.cnt), 0);
    chk("rst_src_a", 32'(dut_a.src), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic count_toggles(input logic [6:0] r, input int want);
    rate = r;
    repeat (10) step();
    toggles = 0;
    prev = lo_a;
    repeat (1000) begin
      step();
      if (lo_a !== prev) toggles++;
      prev = lo_a;
    end
    chk("toggle_count", toggles, want);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rate = 7'd127;
    model_reset();
    #3 rst = 1'b0;
    #1;
    chk("init_lo_a", 32'(lo_a), 0);
    chk("init_lo_b", 32'(lo_b), 0);
    chk("init_cnt", 32'(dut_a.cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    // Full rate from power-up: fixed edge numbers for the first rise
    repeat (20) begin
      step();
      chk("seq1_a", 32'(lo_a), 32'(e >= 6 && ((e - 6) % 2) == 0));
      chk("seq1_b", 32'(lo_b), 32'(e >= 3 && ((e - 3) % 2) == 0));
    end

    // Zero rate from a fresh reset: the chain stays quiet
    rate = 7'd0;
    do_reset();
    repeat (1000) step();
    chk("zero_rate_src", 32'(dut_a.src), 0);

    // Steady-state transition counts
    count_toggles(7'd50, 500);
    count_toggles(7'd1, 10);
    count_toggles(7'd100, 1000);

    // Window wrap with a quarter rate
    rate = 7'd25;
    while ((e % 100) != 99) step();
    chk("cnt_99", 32'(dut_a.cnt), 99);
    chk("en_off_99", 32'(dut_a.en), 0);
    step();
    chk("cnt_wrap", 32'(dut_a.cnt), 0);
    chk("en_on_0", 32'(dut_a.en), 1);
    repeat (110) step();

    // Asynchronous abort mid-run with the output high, then replay sequence 1
    rate = 7'd127;
    do_reset();
    repeat (38) step();
    chk("pre_abort_hi", 32'(lo_a), 1);
    do_reset();
    repeat (20) begin
      step();
      chk("seq5_a", 32'(lo_a), 32'(e >= 6 && ((e - 6) % 2) == 0));
      chk("seq5_b", 32'(lo_b), 32'(e >= 3 && ((e - 3) % 2) == 0));
    end

    // Random rate changes mid-window against the model
    repeat (25) begin
      rate = 7'($urandom_range(0, 127));
      repeat ($urandom_range(1, 150)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
